link_seq_ctrl: RTL and testbench
================================

Name: link_seq_ctrl

Overview:
Central sequencer for the RF-to-SPI receive path and the SPI-to-RF transmit path. In RX mode it detects packet arrival from the shift buffer, loads the packet register and steps through its bytes, one SPI chip-select frame per byte. In TX mode it loads the TX buffer after each SPI frame and paces 8 serial bits out on the synchronized bit strobe. It owns CS synchronization, mode switching, timeout and overrun reporting.

Parameters:
BYTES, 8, bytes per packet presented over SPI (2..15)
TO_W, 16, width of the CS-wait timeout counter; timeout occurs after 2^TO_W-1 idle cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_mode  in  1  1 = RX path, 0 = TX path; requested mode
pkt_rec  in  1  packet-received level from shift buffer (clk domain)
cs  in  1  raw SPI chip select, asynchronous, active low
sh_en_sync  in  1  synchronized bit strobe, one clk per bit
ovr_clr  in  1  clears overrun and timeout flags
pkt_ld  out  1  one-cycle load strobe to packet register
spi_ld  out  1  one-cycle strobe to present byte to SPI slave
pkt_en  out  1  one-cycle byte-advance strobe to packet register
byte_idx  out  4  index of byte currently presented
tx_ld  out  1  one-cycle load strobe to TX buffer
tx_en  out  1  TX buffer shift enable
active_mode  out  1  mode currently in effect
busy  out  1  active FSM not idle
pkt_done  out  1  one-cycle pulse after last RX byte
tx_done  out  1  one-cycle pulse after 8th TX bit
overrun  out  1  sticky: packet arrived while RX busy
timeout  out  1  sticky: CS wait expired

Behaviour:
- Reset: all outputs 0, active_mode=1, both FSMs idle, counters 0, sync flops 1 (CS idle-high).
- CS sync: cs_s1<=cs, cs_s2<=cs_s1, cs_d<=cs_s2; cs_fall = cs_d & ~cs_s2, cs_rise = ~cs_d & cs_s2. FSM acts on an edge 3 clk after cs is first sampled changed.
- pkt_rise = pkt_rec & ~pkt_prev (pkt_prev registered every cycle, both modes).
- Mode: active_mode <= rx_mode only on a cycle where the active FSM is idle; otherwise the request waits. Inactive FSM is held idle; its strobes stay 0.
- RX FSM states R_IDLE, R_WAIT, R_XFER:
  - R_IDLE: on pkt_rise -> pkt_ld=1, spi_ld=1 (same cycle, 1 clk), byte_idx=0, to_cnt=0, -> R_WAIT.
  - R_WAIT: cs_fall -> R_XFER. Else to_cnt++; at all-ones -> timeout=1, -> R_IDLE.
  - R_XFER: cs_rise -> pkt_en=1 for 1 clk. If byte_idx==BYTES-1: pkt_done=1, byte_idx=0, -> R_IDLE. Else byte_idx++, spi_ld=1 next cycle, to_cnt=0, -> R_WAIT.
- TX FSM states T_IDLE, T_SPI, T_SHIFT:
  - T_IDLE: cs_fall -> T_SPI.
  - T_SPI: cs_rise -> tx_ld=1 for 1 clk, bit_cnt=0, -> T_SHIFT.
  - T_SHIFT: tx_en = sh_en_sync registered (1 clk latency); each accepted strobe bit_cnt++. When bit_cnt reaches 8: tx_en=0, tx_done=1, -> T_IDLE. cs_fall during T_SHIFT ignored (frame dropped).
- busy = active FSM not in idle state (R_IDLE/T_IDLE).
- overrun: set on pkt_rise while RX FSM not R_IDLE (incl. the pkt_done cycle); packet dropped, sequence continues. ovr_clr clears overrun and timeout; set wins over simultaneous clear.
- byte_idx never exceeds BYTES-1; bit_cnt never exceeds 8.
- Reset mid-operation: returns everything to reset values next edge; no strobes emitted in the reset cycle.

Test Plan:
- RX nominal, BYTES=8: pkt_rec rise, then 8 CS low/high frames -> pkt_ld+spi_ld one pulse, 8 pkt_en pulses, byte_idx 0..7, pkt_done once, busy low after.
- RX timeout, TO_W=4: pkt_rec rise, no CS -> timeout=1 exactly 15 clk after entering R_WAIT, FSM idle; ovr_clr -> timeout=0.
- Overrun: second pkt_rec rise during byte 3 -> overrun=1, byte_idx continues 4..7, no extra pkt_ld.
- TX nominal: rx_mode=0, CS low/high frame, 10 sh_en_sync pulses -> one tx_ld, exactly 8 tx_en pulses each 1 clk after strobe, tx_done once.
- Mode change while busy: rx_mode 1->0 during byte 2 -> active_mode stays 1 until pkt_done cycle, then 0.
- Reset at TX bit 4: rst 1 clk -> tx_en=0, busy=0, active_mode=1, no tx_done.

Source files
------------

// File: rtl/link_seq_ctrl.sv
// Sequencer for the RF->SPI receive path and the SPI->RF transmit path.
// Owns CS synchronisation, mode switching, byte/bit pacing, timeout and overrun flags.
module link_seq_ctrl #(
   parameter int BYTES = 8,
   parameter int TO_W  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_mode,
   input  logic       pkt_rec,
   input  logic       cs,
   input  logic       sh_en_sync,
   input  logic       ovr_clr,
   output logic       pkt_ld,
   output logic       spi_ld,
   output logic       pkt_en,
   output logic [3:0] byte_idx,
   output logic       tx_ld,
   output logic       tx_en,
   output logic       active_mode,
   output logic       busy,
   output logic       pkt_done,
   output logic       tx_done,
   output logic       overrun,
   output logic       timeout
);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_XFER} rx_st_e;
   typedef enum logic [1:0] {T_IDLE, T_SPI, T_SHIFT} tx_st_e;

   localparam logic [3:0] LAST = 4'(BYTES - 1);

   rx_st_e            rx_q, rx_d;
   tx_st_e            tx_q, tx_d;
   logic              cs_s1_q, cs_s2_q, cs_d_q, pkt_prev_q;
   logic [3:0]        byte_idx_q, byte_idx_d, bit_cnt_q, bit_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              spi_nxt_q, spi_nxt_d, mode_q, mode_d;
   logic              pkt_ld_q, pkt_ld_d, spi_ld_q, spi_ld_d, pkt_en_q, pkt_en_d;
   logic              tx_ld_q, tx_ld_d, tx_en_q, tx_en_d, busy_q, busy_d;
   logic              pkt_done_q, pkt_done_d, tx_done_q, tx_done_d;
   logic              ovr_q, ovr_d, to_q, to_d;
   logic              cs_fall, cs_rise, pkt_rise, idle_now, mode_sw, ovr_set, to_set;

   assign cs_fall  = cs_d_q & ~cs_s2_q;
   assign cs_rise  = ~cs_d_q & cs_s2_q;
   assign pkt_rise = pkt_rec & ~pkt_prev_q;
   assign idle_now = mode_q ? (rx_q == R_IDLE) : (tx_q == T_IDLE);
   // A pending mode switch takes the idle cycle; neither FSM starts on it.
   assign mode_sw  = idle_now & (rx_mode != mode_q);

   always_comb begin
      rx_d       = rx_q;
      tx_d       = tx_q;
      byte_idx_d = byte_idx_q;
      bit_cnt_d  = bit_cnt_q;
      to_cnt_d   = to_cnt_q;
      spi_nxt_d  = 1'b0;
      pkt_ld_d   = 1'b0;
      spi_ld_d   = spi_nxt_q;
      pkt_en_d   = 1'b0;
      tx_ld_d    = 1'b0;
      tx_en_d    = 1'b0;
      pkt_done_d = 1'b0;
      tx_done_d  = 1'b0;
      to_set     = 1'b0;
      mode_d     = idle_now ? rx_mode : mode_q;
      // The pkt_done cycle still counts as busy for overrun purposes.
      ovr_set    = mode_q & pkt_rise & ((rx_q != R_IDLE) | pkt_done_q);

      if (mode_q && !mode_sw) begin
         case (rx_q)
            R_IDLE: if (pkt_rise && !pkt_done_q) begin
               pkt_ld_d   = 1'b1;
               spi_ld_d   = 1'b1;
               byte_idx_d = 4'd0;
               to_cnt_d   = '0;
               rx_d       = R_WAIT;
            end
            R_WAIT: if (cs_fall) begin
               rx_d = R_XFER;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (&to_cnt_d) begin
                  to_set = 1'b1;
                  rx_d   = R_IDLE;
               end
            end
            R_XFER: if (cs_rise) begin
               pkt_en_d = 1'b1;
               if (byte_idx_q == LAST) begin
                  pkt_done_d = 1'b1;
                  byte_idx_d = 4'd0;
                  rx_d       = R_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 4'd1;
                  spi_nxt_d  = 1'b1;
                  to_cnt_d   = '0;
                  rx_d       = R_WAIT;
               end
            end
            default: rx_d = R_IDLE;
         endcase
      end

      if (!mode_q && !mode_sw) begin
         case (tx_q)
            T_IDLE: if (cs_fall) tx_d = T_SPI;
            T_SPI: if (cs_rise) begin
               tx_ld_d   = 1'b1;
               bit_cnt_d = 4'd0;
               tx_d      = T_SHIFT;
            end
            T_SHIFT: if (bit_cnt_q == 4'd8) begin
               tx_done_d = 1'b1;
               bit_cnt_d = 4'd0;
               tx_d      = T_IDLE;
            end else if (sh_en_sync) begin
               tx_en_d   = 1'b1;
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            default: tx_d = T_IDLE;
         endcase
      end

      busy_d = mode_d ? (rx_d != R_IDLE) : (tx_d != T_IDLE);
      ovr_d  = ovr_set | (ovr_q & ~ovr_clr);
      to_d   = to_set | (to_q & ~ovr_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         cs_d_q     <= 1'b1;
         pkt_prev_q <= 1'b0;
         rx_q       <= R_IDLE;
         tx_q       <= T_IDLE;
         byte_idx_q <= 4'd0;
         bit_cnt_q  <= 4'd0;
         to_cnt_q   <= '0;
         spi_nxt_q  <= 1'b0;
         mode_q     <= 1'b1;
         pkt_ld_q   <= 1'b0;
         spi_ld_q   <= 1'b0;
         pkt_en_q   <= 1'b0;
         tx_ld_q    <= 1'b0;
         tx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         tx_done_q  <= 1'b0;
         ovr_q      <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         cs_s1_q    <= cs;
         cs_s2_q    <= cs_s1_q;
         cs_d_q     <= cs_s2_q;
         pkt_prev_q <= pkt_rec;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         byte_idx_q <= byte_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         to_cnt_q   <= to_cnt_d;
         spi_nxt_q  <= spi_nxt_d;
         mode_q     <= mode_d;
         pkt_ld_q   <= pkt_ld_d;
         spi_ld_q   <= spi_ld_d;
         pkt_en_q   <= pkt_en_d;
         tx_ld_q    <= tx_ld_d;
         tx_en_q    <= tx_en_d;
         busy_q     <= busy_d;
         pkt_done_q <= pkt_done_d;
         tx_done_q  <= tx_done_d;
         ovr_q      <= ovr_d;
         to_q       <= to_d;
      end
   end

   assign pkt_ld      = pkt_ld_q;
   assign spi_ld      = spi_ld_q;
   assign pkt_en      = pkt_en_q;
   assign byte_idx    = byte_idx_q;
   assign tx_ld       = tx_ld_q;
   assign tx_en       = tx_en_q;
   assign active_mode = mode_q;
   assign busy        = busy_q;
   assign pkt_done    = pkt_done_q;
   assign tx_done     = tx_done_q;
   assign overrun     = ovr_q;
   assign timeout     = to_q;

endmodule

// File: tb/tb_link_seq_ctrl.sv
// Scoreboard bench for link_seq_ctrl: stimulus queues expected strobes with their
// cycle numbers; a negedge monitor pops and compares every strobe the DUT emits.
module tb_link_seq_ctrl;

   localparam int BYTES = 8;

   logic       clk, rst, rx_mode, pkt_rec, cs, sh_en_sync, ovr_clr;
   logic       pkt_ld, spi_ld, pkt_en, tx_ld, tx_en, active_mode, busy;
   logic       pkt_done, tx_done, overrun, timeout;
   logic [3:0] byte_idx;

   typedef struct {
      string kind;
      int    idx;
      int    cyc;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;

   link_seq_ctrl #(.BYTES(BYTES), .TO_W(4)) dut (
      .clk(clk), .rst(rst), .rx_mode(rx_mode), .pkt_rec(pkt_rec), .cs(cs),
      .sh_en_sync(sh_en_sync), .ovr_clr(ovr_clr), .pkt_ld(pkt_ld), .spi_ld(spi_ld),
      .pkt_en(pkt_en), .byte_idx(byte_idx), .tx_ld(tx_ld), .tx_en(tx_en),
      .active_mode(active_mode), .busy(busy), .pkt_done(pkt_done), .tx_done(tx_done),
      .overrun(overrun), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input string k, input int idx, input int c);
      ev_t e;
      e.kind = k;
      e.idx  = idx;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic see(input string k, input int idx);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: got idx %0d at cyc %0d, expected no strobe", k, idx, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.idx != idx || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL strobe: got %s idx %0d cyc %0d, expected %s idx %0d cyc %0d",
                     k, idx, cyc, e.kind, e.idx, e.cyc);
         end
      end
   endtask

   // Fixed ordering for strobes that share a cycle.
   always @(negedge clk) begin
      if (pkt_ld)   see("pkt_ld", byte_idx);
      if (spi_ld)   see("spi_ld", byte_idx);
      if (pkt_en)   see("pkt_en", byte_idx);
      if (pkt_done) see("pkt_done", byte_idx);
      if (tx_ld)    see("tx_ld", byte_idx);
      if (tx_en)    see("tx_en", byte_idx);
      if (tx_done)  see("tx_done", byte_idx);
   end

   // One CS frame of an RX packet. cs change driven at cycle c is acted on at edge c+3;
   // byte_idx advances on the pkt_en edge, next spi_ld follows one cycle later.
   task automatic rx_frame(input int i, input bit ovr, input bit mchk);
      int m;
      repeat (2) tick();
      cs = 1'b0;
      if (ovr) pkt_rec = 1'b1;
      if (mchk && i == 2) rx_mode = 1'b0;
      tick();
      if (ovr) pkt_rec = 1'b0;
      tick();
      cs = 1'b1;
      m = cyc;
      if (i == BYTES - 1) begin
         push("pkt_en", 0, m + 3);
         push("pkt_done", 0, m + 3);
      end else begin
         push("pkt_en", i + 1, m + 3);
         push("spi_ld", i + 1, m + 4);
      end
      repeat (3) tick();
      if (mchk) chk("mode_hold", active_mode, 1);
      tick();
      if (mchk) chk("mode_after", active_mode, (i == BYTES - 1) ? 0 : 1);
   endtask

   task automatic rx_start(input bit pulse);
      tick();
      pkt_rec = 1'b1;
      push("pkt_ld", 0, cyc + 1);
      push("spi_ld", 0, cyc + 1);
      tick();
      if (pulse) pkt_rec = 1'b0;
   endtask

   task automatic tx_frame(output int k);
      tick();
      cs = 1'b0;
      k = cyc;
      repeat (2) tick();
      cs = 1'b1;
      push("tx_ld", 0, k + 5);
      repeat (3) tick();
   endtask

   initial begin
      int k, s;
      rst = 1'b1; rx_mode = 1'b1; pkt_rec = 1'b0; cs = 1'b1;
      sh_en_sync = 1'b0; ovr_clr = 1'b0;
      repeat (3) tick();
      chk("rst_active_mode", active_mode, 1);
      chk("rst_busy", busy, 0);
      chk("rst_byte_idx", byte_idx, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_tx_en", tx_en, 0);
      rst = 1'b0;

      // RX nominal, pkt_rec held as a level for the whole packet
      rx_start(1'b0);
      chk("rx_busy", busy, 1);
      for (int i = 0; i < BYTES; i++) rx_frame(i, 1'b0, 1'b0);
      tick();
      chk("rx_idle", busy, 0);
      chk("rx_no_ovr", overrun, 0);
      chk("rx_no_to", timeout, 0);
      pkt_rec = 1'b0;

      // Overrun: second arrival during byte 3, sequence runs to completion
      rx_start(1'b1);
      for (int i = 0; i < BYTES; i++) rx_frame(i, i == 3, 1'b0);
      tick();
      chk("ovr_set", overrun, 1);
      chk("ovr_idle", busy, 0);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr", overrun, 0);

      // Timeout: R_WAIT entered on the pkt_ld edge, flag 15 clk later
      tick();
      pkt_rec = 1'b1;
      k = cyc;
      push("pkt_ld", 0, k + 1);
      push("spi_ld", 0, k + 1);
      tick();
      pkt_rec = 1'b0;
      repeat (14) tick();
      chk("to_early", timeout, 0);
      chk("to_busy", busy, 1);
      tick();
      chk("to_set", timeout, 1);
      chk("to_idle", busy, 0);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("to_clr", timeout, 0);

      // Mode change requested during byte 2 takes effect after pkt_done
      rx_start(1'b1);
      for (int i = 0; i < BYTES; i++) rx_frame(i, 1'b0, 1'b1);
      tick();
      chk("tx_mode", active_mode, 0);

      // TX nominal: 10 strobes, only 8 shifted; CS edges mid-shift are dropped
      tx_frame(k);
      for (int j = 0; j < 10; j++) begin
         tick();
         sh_en_sync = 1'b1;
         s = cyc;
         if (j < 8) push("tx_en", 0, s + 1);
         if (j == 7) push("tx_done", 0, s + 2);
         if (j == 3) cs = 1'b0;
         if (j == 5) cs = 1'b1;
         tick();
         sh_en_sync = 1'b0;
      end
      repeat (3) tick();
      chk("tx_idle", busy, 0);

      // Reset after the 4th bit
      tx_frame(k);
      for (int j = 0; j < 4; j++) begin
         tick();
         sh_en_sync = 1'b1;
         push("tx_en", 0, cyc + 1);
         tick();
         sh_en_sync = 1'b0;
      end
      chk("tx_mid_busy", busy, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_tx_en", tx_en, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_mode", active_mode, 1);
      tick();
      chk("rst_mode_follow", active_mode, 0);
      repeat (12) tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
